fir_axil_slave: RTL and testbench

AXI4-Lite slave register interface for the FIR filter IP: the responder that terminates the S00_AXI port driven by the AXI VIP master in the block-design bench. It holds four 32-bit read/write registers at offsets 0x0, 0x4, 0x8 and 0xC, and exports them to the filter core along with per-register write pulses. Write and read channels run independently, each with its own FSM.

---
 rtl/fir_axil_pkg.sv | 38 +++
 rtl/fir_axil_regbank.sv | 49 ++++
 rtl/fir_axil_slave.sv | 209 ++++++++++++++++++++
 tb/tb_fir_axil_slave.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_axil_pkg.sv
// Shared definitions for the FIR filter AXI4-Lite register slave.
package fir_axil_pkg;

  localparam logic [3:0] REG0_OFF  = 4'h0;
  localparam logic [3:0] REG1_OFF  = 4'h4;
  localparam logic [3:0] REG2_OFF  = 4'h8;
  localparam logic [3:0] REG3_OFF  = 4'hC;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Byte lane k takes the new byte only where its strobe bit is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) begin
        merged[8*k +: 8] = new_val[8*k +: 8];
      end else begin
        merged[8*k +: 8] = old_val[8*k +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/fir_axil_regbank.sv
// Four 32-bit control registers with byte-strobe write and combinational read mux.
module fir_axil_regbank
  import fir_axil_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit,
  input  logic [1:0]  widx,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic [1:0]  ridx,
  output logic [31:0] rdata,
  output logic [31:0] reg0,
  output logic [31:0] reg1,
  output logic [31:0] reg2,
  output logic [31:0] reg3
);

  logic [31:0] regs_r [4];

  // Register storage, updated on the commit strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (commit) begin
      regs_r[widx] <= strb_merge(regs_r[widx], wdata, wstrb);
    end
  end

  // Read mux; sees pre-commit contents during a same-cycle write.
  always_comb begin
    rdata = 32'd0;
    case (ridx)
      2'd0:    rdata = regs_r[0];
      2'd1:    rdata = regs_r[1];
      2'd2:    rdata = regs_r[2];
      2'd3:    rdata = regs_r[3];
      default: rdata = 32'd0;
    endcase
  end

  assign reg0 = regs_r[0];
  assign reg1 = regs_r[1];
  assign reg2 = regs_r[2];
  assign reg3 = regs_r[3];

endmodule

// File: rtl/fir_axil_slave.sv
// AXI4-Lite slave for the FIR IP: independent write and read FSMs over a 4-register bank.
module fir_axil_slave
  import fir_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0] s00_axi_awaddr,
  input  logic [2:0]            s00_axi_awprot,
  input  logic                  s00_axi_awvalid,
  output logic                  s00_axi_awready,
  input  logic [DATA_WIDTH-1:0] s00_axi_wdata,
  input  logic [3:0]            s00_axi_wstrb,
  input  logic                  s00_axi_wvalid,
  output logic                  s00_axi_wready,
  output logic [1:0]            s00_axi_bresp,
  output logic                  s00_axi_bvalid,
  input  logic                  s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s00_axi_araddr,
  input  logic [2:0]            s00_axi_arprot,
  input  logic                  s00_axi_arvalid,
  output logic                  s00_axi_arready,
  output logic [DATA_WIDTH-1:0] s00_axi_rdata,
  output logic [1:0]            s00_axi_rresp,
  output logic                  s00_axi_rvalid,
  input  logic                  s00_axi_rready,
  output logic [31:0]           reg0_o,
  output logic [31:0]           reg1_o,
  output logic [31:0]           reg2_o,
  output logic [31:0]           reg3_o,
  output logic [3:0]            wr_pulse_o
);

  w_state_t    w_state_r;
  r_state_t    r_state_r;
  logic        awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
  logic [1:0]  widx_r;
  logic [31:0] wdata_r, rdata_r;
  logic [3:0]  wstrb_r, wr_pulse_r;
  logic        aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic [1:0]  cidx_s;
  logic [31:0] cdata_s, mux_rdata_s;
  logic [3:0]  cstrb_s;
  logic        unused_ok;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign aw_hs_s = s00_axi_awvalid & awready_r;
  assign w_hs_s  = s00_axi_wvalid  & wready_r;
  assign ar_hs_s = s00_axi_arvalid & arready_r;

  // Commit fires on the edge that completes the second of the AW/W handshakes.
  always_comb begin
    commit_s = 1'b0;
    cidx_s   = widx_r;
    cdata_s  = s00_axi_wdata;
    cstrb_s  = s00_axi_wstrb;
    case (w_state_r)
      W_IDLE: begin
        cidx_s = s00_axi_awaddr[3:2];
        if (aw_hs_s && w_hs_s) commit_s = 1'b1;
        else                   commit_s = 1'b0;
      end
      W_HAVE_ADDR: begin
        if (w_hs_s) commit_s = 1'b1;
        else        commit_s = 1'b0;
      end
      W_HAVE_DATA: begin
        cidx_s  = s00_axi_awaddr[3:2];
        cdata_s = wdata_r;
        cstrb_s = wstrb_r;
        if (aw_hs_s) commit_s = 1'b1;
        else         commit_s = 1'b0;
      end
      default: commit_s = 1'b0;
    endcase
  end

  // Write-channel FSM with registered readys, bvalid and commit pulse.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      w_state_r  <= W_IDLE;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      widx_r     <= 2'd0;
      wdata_r    <= 32'd0;
      wstrb_r    <= 4'd0;
      wr_pulse_r <= 4'd0;
    end else begin
      wr_pulse_r <= commit_s ? (4'b0001 << cidx_s) : 4'b0000;
      case (w_state_r)
        W_IDLE: begin
          if (aw_hs_s && w_hs_s) begin
            w_state_r <= W_RESP;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b1;
          end else if (aw_hs_s) begin
            widx_r    <= s00_axi_awaddr[3:2];
            w_state_r <= W_HAVE_ADDR;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
          end else if (w_hs_s) begin
            wdata_r   <= s00_axi_wdata;
            wstrb_r   <= s00_axi_wstrb;
            w_state_r <= W_HAVE_DATA;
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
          end else begin
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end
        end
        W_HAVE_ADDR: begin
          if (w_hs_s) begin
            w_state_r <= W_RESP;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b1;
          end
        end
        W_HAVE_DATA: begin
          if (aw_hs_s) begin
            w_state_r <= W_RESP;
            awready_r <= 1'b0;
            bvalid_r  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            w_state_r <= W_IDLE;
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read-channel FSM; rdata is captured at the AR handshake and held.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'd0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (ar_hs_s) begin
            rdata_r   <= mux_rdata_s;
            rvalid_r  <= 1'b1;
            arready_r <= 1'b0;
            r_state_r <= R_DATA;
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_DATA: begin
          if (s00_axi_rready) begin
            rvalid_r  <= 1'b0;
            arready_r <= 1'b1;
            r_state_r <= R_IDLE;
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b0;
          rvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  fir_axil_regbank u_regbank (
    .clk    (s00_axi_aclk),
    .rst_n  (s00_axi_aresetn),
    .commit (commit_s),
    .widx   (cidx_s),
    .wdata  (cdata_s),
    .wstrb  (cstrb_s),
    .ridx   (s00_axi_araddr[3:2]),
    .rdata  (mux_rdata_s),
    .reg0   (reg0_o),
    .reg1   (reg1_o),
    .reg2   (reg2_o),
    .reg3   (reg3_o)
  );

  assign s00_axi_awready = awready_r;
  assign s00_axi_wready  = wready_r;
  assign s00_axi_bvalid  = bvalid_r;
  assign s00_axi_bresp   = RESP_OKAY;
  assign s00_axi_arready = arready_r;
  assign s00_axi_rvalid  = rvalid_r;
  assign s00_axi_rdata   = rdata_r;
  assign s00_axi_rresp   = RESP_OKAY;
  assign wr_pulse_o      = wr_pulse_r;

endmodule

// File: tb/tb_fir_axil_slave.sv
// Directed self-checking bench for fir_axil_slave: vector table plus handshake corner cases.
module tb_fir_axil_slave;
  import fir_axil_pkg::*;

  logic        clk, rst_n;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb, wr_pulse;
  logic [1:0]  bresp, rresp;
  logic [31:0] reg0, reg1, reg2, reg3;

  int n_tests = 0;
  int n_fail  = 0;

  fir_axil_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3), .wr_pulse_o(wr_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        is_read;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [3:0]  exp_pulse;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_by_idx(input logic [1:0] i);
    case (i)
      2'd0:    return reg0;
      2'd1:    return reg1;
      2'd2:    return reg2;
      default: return reg3;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full write: AW and W together, result values captured in the bvalid cycle.
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [3:0] pulse, output logic [31:0] regv, output logic [1:0] resp);
    logic aw_done, w_done, aw_hit, w_hit;
    int   cyc;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 20) begin
      aw_hit = awvalid && awready;
      w_hit  = wvalid && wready;
      step();
      if (aw_hit) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_hit)  begin w_done  = 1'b1; wvalid  = 1'b0; end
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) check("write_hs_timeout", 32'd0, 32'd1);
    cyc = 0;
    while (!bvalid && cyc < 20) begin step(); cyc++; end
    if (!bvalid) check("bvalid_timeout", 32'd0, 32'd1);
    pulse = wr_pulse; regv = reg_by_idx(a[3:2]); resp = bresp;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic hit;
    int   cyc;
    araddr = a; arvalid = 1'b1; hit = 1'b0; cyc = 0;
    while (!hit && cyc < 20) begin
      hit = arready;
      step();
      cyc++;
    end
    arvalid = 1'b0;
    if (!hit) check("read_hs_timeout", 32'd0, 32'd1);
    cyc = 0;
    while (!rvalid && cyc < 20) begin step(); cyc++; end
    if (!rvalid) check("rvalid_timeout", 32'd0, 32'd1);
    d = rdata; resp = rresp;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  initial begin
    logic [3:0]  pulse;
    logic [31:0] v;
    logic [1:0]  resp;

    vecs[0]  = '{1'b0, REG0_OFF, 32'h1,        4'hF,    32'h1,        4'b0001};
    vecs[1]  = '{1'b0, REG1_OFF, 32'h2,        4'hF,    32'h2,        4'b0010};
    vecs[2]  = '{1'b0, REG2_OFF, 32'h3,        4'hF,    32'h3,        4'b0100};
    vecs[3]  = '{1'b0, REG3_OFF, 32'h4,        4'hF,    32'h4,        4'b1000};
    vecs[4]  = '{1'b1, REG0_OFF, 32'h0,        4'h0,    32'h1,        4'b0000};
    vecs[5]  = '{1'b1, REG1_OFF, 32'h0,        4'h0,    32'h2,        4'b0000};
    vecs[6]  = '{1'b1, REG2_OFF, 32'h0,        4'h0,    32'h3,        4'b0000};
    vecs[7]  = '{1'b1, REG3_OFF, 32'h0,        4'h0,    32'h4,        4'b0000};
    vecs[8]  = '{1'b0, 4'h4,     32'hAABBCCDD, 4'b1111, 32'hAABBCCDD, 4'b0010};
    vecs[9]  = '{1'b0, 4'h5,     32'h11223344, 4'b0101, 32'hAA22CC44, 4'b0010};
    vecs[10] = '{1'b1, 4'h7,     32'h0,        4'h0,    32'hAA22CC44, 4'b0000};
    vecs[11] = '{1'b0, 4'h0,     32'hFFFFFFFF, 4'b0000, 32'h1,        4'b0001};
    vecs[12] = '{1'b1, 4'h2,     32'h0,        4'h0,    32'h1,        4'b0000};

    rst_n = 1'b0; awaddr = 4'd0; araddr = 4'd0; awprot = 3'd0; arprot = 3'd0;
    awvalid = 1'b0; wvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; bready = 1'b0;
    arvalid = 1'b0; rready = 1'b0;

    // Reset state
    step(); step();
    check("rst_readys", {29'd0, awready, wready, arready}, 32'd0);
    check("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
    check("rst_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
    check("rst_pulse_rdata", {28'd0, wr_pulse} | rdata, 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_readys", {29'd0, awready, wready, arready}, 32'd7);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].is_read) begin
        do_read(vecs[i].addr, v, resp);
        check($sformatf("vec%0d_rdata", i), v, vecs[i].exp);
        check($sformatf("vec%0d_rresp", i), {30'd0, resp}, {30'd0, RESP_OKAY});
      end else begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, pulse, v, resp);
        check($sformatf("vec%0d_reg", i), v, vecs[i].exp);
        check($sformatf("vec%0d_pulse", i), {28'd0, pulse}, {28'd0, vecs[i].exp_pulse});
        check($sformatf("vec%0d_bresp", i), {30'd0, resp}, {30'd0, RESP_OKAY});
      end
    end

    // W three cycles ahead of AW
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    check("wfirst_wready", {31'd0, wready}, 32'd1);
    step();
    wvalid = 1'b0;
    check("wfirst_wready_low", {31'd0, wready}, 32'd0);
    step(); step();
    check("wfirst_no_bvalid", {31'd0, bvalid}, 32'd0);
    check("wfirst_awready", {31'd0, awready}, 32'd1);
    awaddr = REG2_OFF; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    check("wfirst_bvalid", {31'd0, bvalid}, 32'd1);
    check("wfirst_reg2", reg2, 32'hDEADBEEF);
    check("wfirst_pulse", {28'd0, wr_pulse}, 32'h4);
    bready = 1'b1; step(); bready = 1'b0;

    // Response backpressure with a second write pending
    awaddr = REG0_OFF; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    wdata = 32'h88;
    check("bp_bvalid", {31'd0, bvalid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold%0d", c), {29'd0, bvalid, bresp}, {29'd0, 1'b1, RESP_OKAY});
      check($sformatf("bp_awready%0d", c), {30'd0, awready, wready}, 32'd0);
      step();
    end
    check("bp_reg0_kept", reg0, 32'h77);
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1; step(); bready = 1'b0;
    check("bp_released", {30'd0, bvalid, awready}, 32'd1);
    do_write(REG0_OFF, 32'h88, 4'hF, pulse, v, resp);
    check("bp_next_write", v, 32'h88);

    // Same-cycle read and commit to register 3
    awaddr = REG3_OFF; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = REG3_OFF; arvalid = 1'b1;
    check("coll_readys", {29'd0, awready, wready, arready}, 32'd7);
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("coll_rvalid_bvalid", {30'd0, rvalid, bvalid}, 32'd3);
    check("coll_rdata_old", rdata, 32'h4);
    check("coll_reg3_new", reg3, 32'h55);
    bready = 1'b1; rready = 1'b1; step(); bready = 1'b0; rready = 1'b0;
    do_read(REG3_OFF, v, resp);
    check("coll_reread", v, 32'h55);

    // Reset while holding an address
    awaddr = REG1_OFF; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    check("mid_have_addr", {30'd0, awready, wready}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
    check("mid_rst_readys", {29'd0, awready, wready, bvalid}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("mid_no_bvalid%0d", c), {31'd0, bvalid}, 32'd0);
    end
    do_write(REG1_OFF, 32'h9, 4'hF, pulse, v, resp);
    check("mid_next_write", v, 32'h9);
    check("mid_next_pulse", {28'd0, pulse}, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
